// File: rtl/gray_step_sequencer.sv
// gray_step_sequencer
//
// Runs a commanded number of steps through a WIDTH-bit binary position,
// counting up or down, and presents the Gray code of that position on a
// registered output. One command is accepted at a time; a single-cycle
// done pulse marks completion. The position persists across commands and
// is cleared only by reset.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : synchronous, active-high; clears position and control state
//   cmd_valid  : command request, honoured only while cmd_ready is high
//   cmd_ready  : high in IDLE (a command can be accepted)
//   cmd_steps  : number of steps for the command (0 .. 2^WIDTH-1)
//   cmd_dir    : 0 = count up, 1 = count down
//   pause      : holds the current step while high (only meaningful in RUN)
//   gray_out   : registered Gray code of the internal position
//   busy       : high while in RUN
//   done       : high for the single DONE cycle
module gray_step_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             pause,
    output logic [WIDTH-1:0] gray_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pos, pos_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic             dir_q, dir_nxt;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        rem_nxt   = rem;
        dir_nxt   = dir_q;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    rem_nxt   = cmd_steps;
                    dir_nxt   = cmd_dir;
                    // A zero-step command completes without ever entering RUN.
                    state_nxt = (cmd_steps != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Pause freezes everything, including the final step.
                if (!pause) begin
                    pos_nxt = dir_q ? (pos - ONE) : (pos + ONE);
                    rem_nxt = rem - ONE;
                    if (rem == ONE) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; gray_out is derived from pos_nxt so it moves on the
    // same edge as pos.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pos      <= '0;
            rem      <= '0;
            dir_q    <= 1'b0;
            gray_out <= '0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            rem      <= rem_nxt;
            dir_q    <= dir_nxt;
            gray_out <= bin2gray(pos_nxt);
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_gray_step_sequencer.sv
// Directed bench for gray_step_sequencer: a cycle-by-cycle vector table
// followed by a hand-written down-count sequence with a bounded wait.
module tb_gray_step_sequencer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_steps;
    logic             cmd_dir;
    logic             pause;
    logic [WIDTH-1:0] gray_out;
    logic             busy;
    logic             done;

    gray_step_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_dir   (cmd_dir),
        .pause     (pause),
        .gray_out  (gray_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One row = inputs held across one rising edge, then outputs expected
    // one time unit after that edge.
    typedef struct {
        logic             rst;
        logic             vld;
        logic [WIDTH-1:0] steps;
        logic             dir;
        logic             pse;
        logic [WIDTH-1:0] gray;
        logic             busy;
        logic             done;
        logic             ready;
        string            name;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_fail    = 0;

    task automatic add(input string name, input logic rst, input logic vld,
                       input logic [WIDTH-1:0] steps, input logic dir, input logic pse,
                       input logic [WIDTH-1:0] gray, input logic b, input logic d,
                       input logic r);
        vec_t v;
        v.name = name; v.rst = rst; v.vld = vld; v.steps = steps; v.dir = dir;
        v.pse = pse; v.gray = gray; v.busy = b; v.done = d; v.ready = r;
        vecs.push_back(v);
    endtask

    function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [WIDTH-1:0] up_seq [15];
    logic [WIDTH-1:0] prev_gray;
    int               busy_cnt;
    int               changes;
    bit               seen_done;

    initial begin
        up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                   4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001,
                   4'b1000};

        //   name         rst vld steps dir pse   gray   busy done ready
        add("reset0",     1, 0, 4'd0, 0, 0, 4'b0000, 0, 0, 1);
        add("reset1",     1, 1, 4'd5, 0, 1, 4'b0000, 0, 0, 1);
        add("idle",       0, 0, 4'd0, 0, 0, 4'b0000, 0, 0, 1);
        // Full up sequence, 15 steps.
        add("up_accept",  0, 1, 4'd15, 0, 0, 4'b0000, 1, 0, 0);
        for (int i = 0; i < 14; i++)
            add($sformatf("up_step%0d", i + 1), 0, 0, 4'd0, 0, 0, up_seq[i], 1, 0, 0);
        add("up_step15",  0, 0, 4'd0, 0, 0, 4'b1000, 0, 1, 0);
        add("up_idle",    0, 0, 4'd0, 0, 0, 4'b1000, 0, 0, 1);
        // Wrap up from 15 to 0.
        add("wrap_acc",   0, 1, 4'd1, 0, 0, 4'b1000, 1, 0, 0);
        add("wrap_step",  0, 0, 4'd0, 0, 0, 4'b0000, 0, 1, 0);
        add("wrap_idle",  0, 0, 4'd0, 0, 0, 4'b0000, 0, 0, 1);
        // Wrap down from 0 to 15, then 14.
        add("dn_acc",     0, 1, 4'd2, 1, 0, 4'b0000, 1, 0, 0);
        add("dn_step1",   0, 0, 4'd0, 0, 0, 4'b1000, 1, 0, 0);
        add("dn_step2",   0, 0, 4'd0, 0, 0, 4'b1001, 0, 1, 0);
        add("dn_idle",    0, 0, 4'd0, 0, 0, 4'b1001, 0, 0, 1);
        // Zero-step command, with pause high in IDLE and DONE (no effect).
        add("zero_acc",   0, 1, 4'd0, 0, 1, 4'b1001, 0, 1, 0);
        add("zero_idle",  0, 0, 4'd0, 0, 1, 4'b1001, 0, 0, 1);
        // Six up steps from pos 14, paused 3 cycles after step 2; a command
        // presented during RUN must be ignored.
        add("pz_acc",     0, 1, 4'd6, 0, 0, 4'b1001, 1, 0, 0);
        add("pz_step1",   0, 0, 4'd0, 0, 0, 4'b1000, 1, 0, 0);
        add("pz_step2",   0, 0, 4'd0, 0, 0, 4'b0000, 1, 0, 0);
        add("pz_hold1",   0, 0, 4'd0, 0, 1, 4'b0000, 1, 0, 0);
        add("pz_hold2",   0, 1, 4'd3, 1, 1, 4'b0000, 1, 0, 0);
        add("pz_hold3",   0, 0, 4'd0, 0, 1, 4'b0000, 1, 0, 0);
        add("pz_step3",   0, 0, 4'd0, 0, 0, 4'b0001, 1, 0, 0);
        add("pz_step4",   0, 1, 4'd1, 1, 0, 4'b0011, 1, 0, 0);
        add("pz_step5",   0, 0, 4'd0, 0, 0, 4'b0010, 1, 0, 0);
        add("pz_step6",   0, 0, 4'd0, 0, 0, 4'b0110, 0, 1, 0);
        add("pz_idle",    0, 0, 4'd0, 0, 0, 4'b0110, 0, 0, 1);
        // Pause on the final step; command offered in DONE is dropped.
        add("pf_acc",     0, 1, 4'd1, 0, 0, 4'b0110, 1, 0, 0);
        add("pf_hold",    0, 0, 4'd0, 0, 1, 4'b0110, 1, 0, 0);
        add("pf_step",    0, 0, 4'd0, 0, 0, 4'b0111, 0, 1, 0);
        add("pf_done_cmd",0, 1, 4'd5, 0, 0, 4'b0111, 0, 0, 1);
        add("pf_idle",    0, 0, 4'd0, 0, 0, 4'b0111, 0, 0, 1);
        // Abort a 10-step command with reset after step 5.
        add("ab_acc",     0, 1, 4'd10, 0, 0, 4'b0111, 1, 0, 0);
        add("ab_step1",   0, 0, 4'd0, 0, 0, 4'b0101, 1, 0, 0);
        add("ab_step2",   0, 0, 4'd0, 0, 0, 4'b0100, 1, 0, 0);
        add("ab_step3",   0, 0, 4'd0, 0, 0, 4'b1100, 1, 0, 0);
        add("ab_step4",   0, 0, 4'd0, 0, 0, 4'b1101, 1, 0, 0);
        add("ab_step5",   0, 0, 4'd0, 0, 0, 4'b1111, 1, 0, 0);
        add("ab_reset",   1, 0, 4'd0, 0, 0, 4'b0000, 0, 0, 1);
        add("ab_after1",  0, 0, 4'd0, 0, 0, 4'b0000, 0, 0, 1);
        add("ab_after2",  0, 0, 4'd0, 0, 0, 4'b0000, 0, 0, 1);

        reset = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; pause = 1'b0;
        #2;

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            cmd_valid = vecs[i].vld;
            cmd_steps = vecs[i].steps;
            cmd_dir   = vecs[i].dir;
            pause     = vecs[i].pse;
            @(posedge clk);
            #1;
            check(vecs[i].name, {25'd0, gray_out, busy, done, cmd_ready},
                  {25'd0, vecs[i].gray, vecs[i].busy, vecs[i].done, vecs[i].ready});
        end

        // Nine down steps from 0 must end at position 7 with every
        // visible change flipping exactly one bit.
        reset = 1'b1; cmd_valid = 1'b0; pause = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; cmd_valid = 1'b1; cmd_steps = 4'd9; cmd_dir = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
        busy_cnt  = busy ? 1 : 0;
        prev_gray = gray_out;
        changes   = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            @(posedge clk); #1;
            if (gray_out !== prev_gray) begin
                changes++;
                check($sformatf("seq_onebit%0d", changes),
                      32'($countones(gray_out ^ prev_gray)), 32'd1);
                prev_gray = gray_out;
            end
            if (busy) busy_cnt++;
            if (done) seen_done = 1'b1;
        end
        check("seq_done_seen", {31'd0, seen_done}, 32'd1);
        check("seq_final_gray", {28'd0, gray_out}, {28'd0, b2g(4'(0 - 9))});
        check("seq_busy_cycles", 32'(busy_cnt), 32'd9);
        check("seq_changes", 32'(changes), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
